// File: rtl/crc_frame_pkg.sv
// rtl/crc_frame_pkg.sv - shared types, constants and CRC step for the frame checker
package crc_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hFFFFFFFF;
    localparam int          CHECK_BITS  = 32;

    // One MSB-first division step: the new bit enters at the bottom and the
    // bit falling off the top decides whether the polynomial is folded in.
    function automatic logic [31:0] crc_step(input logic [31:0] r, input logic b);
        return {r[30:0], b} ^ (r[31] ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_lfsr.sv
// rtl/crc32_lfsr.sv - bit-serial CRC-32 engine register
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : zero the register (wins over shift_i)
//   shift_i, bit_i : shift bit_i into the register this edge
//   crc_o          : live register value
module crc32_lfsr
    import crc_frame_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic        bit_i,
    output logic [31:0] crc_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            crc_o <= 32'h0;
        end else if (clear_i) begin
            crc_o <= 32'h0;
        end else if (shift_i) begin
            crc_o <= crc_step(crc_o, bit_i);
        end
    end

endmodule

// File: rtl/crc_frame_ctrl.sv
// rtl/crc_frame_ctrl.sv - sequences the CRC-32 engine over one received frame
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   start_i, len_i        : begin a frame of len_i payload bytes (IDLE only)
//   bit_valid_i, bit_i    : serial bit strobe and data
//   abort_i               : abandon the current frame, no completion pulse
//   busy_o                : frame in progress (payload or check field)
//   done_o                : one-cycle completion pulse
//   ok_o, timeout_o       : frame verdict, held until the next accepted start
//   residue_o             : live engine register
module crc_frame_ctrl
    import crc_frame_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ok_o,
    output logic             timeout_o,
    output logic [31:0]      residue_o
);

    localparam int CNT_W = LEN_W + 3;
    // Wide enough to hold TIMEOUT itself; never narrower than one bit.
    localparam int TO_W  = $clog2(TIMEOUT + 2);

    localparam logic [CNT_W-1:0] CNT_CHECK = CNT_W'(CHECK_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [31:0]        crc;

    logic               active;
    logic               take_bit;
    logic               lfsr_clear;
    logic               to_hit;
    logic [31:0]        crc_next;

    assign active     = (state == ST_PAYLOAD) || (state == ST_CHECK);
    // Abort outranks a coincident bit: that bit is never shifted in.
    assign take_bit   = active && bit_valid_i && !abort_i;
    assign lfsr_clear = (state == ST_IDLE) && start_i;
    // A bit on the same edge clears the idle count, so it outranks the timeout.
    assign to_hit     = (TIMEOUT != 0) && active && !abort_i && !bit_valid_i
                        && (to_cnt == TO_LAST);
    // Value the engine will hold after this edge; lets the verdict be
    // registered together with the final shift instead of a cycle later.
    assign crc_next   = crc_step(crc, bit_i);

    crc32_lfsr u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (lfsr_clear),
        .shift_i (take_bit),
        .bit_i   (bit_i),
        .crc_o   (crc)
    );

    assign residue_o = crc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            ok_o      <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        ok_o      <= 1'b0;
                        timeout_o <= 1'b0;
                        to_cnt    <= '0;
                        busy_o    <= 1'b1;
                        if (len_i == '0) begin
                            state   <= ST_CHECK;
                            bit_cnt <= CNT_CHECK;
                        end else begin
                            state   <= ST_PAYLOAD;
                            bit_cnt <= {len_i, 3'b000};
                        end
                    end
                end

                ST_PAYLOAD, ST_CHECK: begin
                    if (abort_i) begin
                        state     <= ST_IDLE;
                        busy_o    <= 1'b0;
                        ok_o      <= 1'b0;
                        timeout_o <= 1'b0;
                        bit_cnt   <= '0;
                        to_cnt    <= '0;
                    end else if (bit_valid_i) begin
                        to_cnt <= '0;
                        if (bit_cnt == CNT_ONE) begin
                            if (state == ST_PAYLOAD) begin
                                state   <= ST_CHECK;
                                bit_cnt <= CNT_CHECK;
                            end else begin
                                state     <= ST_DONE;
                                busy_o    <= 1'b0;
                                done_o    <= 1'b1;
                                bit_cnt   <= '0;
                                ok_o      <= (crc_next == CRC_RESIDUE);
                                timeout_o <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - CNT_ONE;
                        end
                    end else if (to_hit) begin
                        state     <= ST_DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        ok_o      <= 1'b0;
                        timeout_o <= 1'b1;
                        to_cnt    <= to_cnt + TO_ONE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb/tb_crc_frame_ctrl.sv - self-checking bench for crc_frame_ctrl
module tb_crc_frame_ctrl;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam int          TO   = 16;

    typedef logic [7:0] bq_t[$];
    typedef enum int {M_IDLE, M_RUN, M_DONE} mmode_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] len_i = '0;
    logic        bit_valid_i = 1'b0;
    logic        bit_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, ok_o, timeout_o;
    logic [31:0] residue_o;

    always #5 clk = ~clk;

    crc_frame_ctrl #(.LEN_W(16), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .bit_valid_i (bit_valid_i),
        .bit_i       (bit_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ok_o        (ok_o),
        .timeout_o   (timeout_o),
        .residue_o   (residue_o)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Textbook MSB-first CRC over whole bytes, init 0, no xorout.
    function automatic logic [31:0] crc_raw(input bq_t d);
        logic [31:0] c;
        c = 32'h0;
        foreach (d[i]) begin
            c ^= {d[i], 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] cksum(input bq_t d);
        return crc_raw(d) ^ 32'hFFFFFFFF;
    endfunction

    // Frame-level reference model
    mmode_t      m_mode;
    int          m_need, m_quiet, m_len;
    logic        m_bits[$];
    logic        exp_ok, exp_to, exp_res_valid;
    logic [31:0] exp_res;

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_bits.delete();
        m_quiet = 0;
        exp_ok = 1'b0;
        exp_to = 1'b0;
        exp_res = 32'h0;
        exp_res_valid = 1'b1;
    endfunction

    function automatic void finish_frame();
        bq_t         pay;
        logic [31:0] cw;
        logic [7:0]  b;
        for (int i = 0; i < m_len; i++) begin
            for (int k = 0; k < 8; k++) b[7-k] = m_bits[i*8+k];
            pay.push_back(b);
        end
        for (int k = 0; k < 32; k++) cw[31-k] = m_bits[m_len*8+k];
        // Engine is plain division of the received polynomial, so the
        // remainder is the payload CRC plus the received check field.
        exp_res = crc_raw(pay) ^ cw;
        exp_ok = (cw == cksum(pay));
        exp_to = 1'b0;
        exp_res_valid = 1'b1;
        m_mode = M_DONE;
    endfunction

    function automatic void model_step();
        if (reset_i) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: if (start_i) begin
                m_mode = M_RUN;
                m_len = int'(len_i);
                m_need = m_len * 8 + 32;
                m_bits.delete();
                m_quiet = 0;
                exp_ok = 1'b0;
                exp_to = 1'b0;
                exp_res = 32'h0;
                exp_res_valid = 1'b1;
            end
            M_RUN: begin
                if (abort_i) begin
                    m_mode = M_IDLE;
                end else if (bit_valid_i) begin
                    m_bits.push_back(bit_i);
                    m_quiet = 0;
                    exp_res_valid = 1'b0;
                    if (m_bits.size() == m_need) finish_frame();
                end else begin
                    m_quiet++;
                    if (m_quiet == TO) begin
                        m_mode = M_DONE;
                        exp_ok = 1'b0;
                        exp_to = 1'b1;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy_o", busy_o, m_mode == M_RUN);
            chk("done_o", done_o, m_mode == M_DONE);
            chk("ok_o", ok_o, exp_ok);
            chk("timeout_o", timeout_o, exp_to);
            if (exp_res_valid) chk("residue_o", residue_o, exp_res);
        end
    end

    task automatic cyc(input logic s, input logic [15:0] l, input logic bv,
                       input logic b, input logic ab);
        start_i = s;
        len_i = l;
        bit_valid_i = bv;
        bit_i = b;
        abort_i = ab;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Start a frame and send its bits; stops right after the final bit edge
    // (or after the abort edge) so the caller can inspect the done cycle.
    task automatic send_bits(input bq_t pay, input logic [31:0] cw, input int gap_max,
                             input int abort_at, input bit noise);
        logic bits[$];
        for (int i = 0; i < pay.size(); i++)
            for (int k = 7; k >= 0; k--) bits.push_back(pay[i][k]);
        for (int k = 31; k >= 0; k--) bits.push_back(cw[k]);
        cyc(1'b1, 16'(pay.size()), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < bits.size(); i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int j = 0; j < g; j++)
                cyc(noise && ($urandom % 4 == 0), 16'($urandom), 1'b0, 1'($urandom), 1'b0);
            if (i == abort_at) begin
                cyc(1'b0, 16'h0, 1'b1, bits[i], 1'b1);
                return;
            end
            cyc(noise && ($urandom % 4 == 0), 16'($urandom), 1'b1, bits[i], 1'b0);
        end
    endtask

    function automatic bq_t digits();
        bq_t p;
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t p;
        bq_t empty;
        int  k;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_ok", ok_o, 0);
        chk("reset_timeout", timeout_o, 0);
        chk("reset_residue", residue_o, 0);
        cmp_en = 1'b1;
        idle(1);
        reset_i = 1'b0;
        idle(2);

        // Pin the model against the published check value
        p = digits();
        chk("model_cksum_123456789", cksum(p), 32'h765E7680);

        // Good frame, back-to-back bits
        send_bits(p, 32'h765E7680, 0, -1, 1'b0);
        chk("t1_done", done_o, 1);
        chk("t1_ok", ok_o, 1);
        chk("t1_timeout", timeout_o, 0);
        chk("t1_residue", residue_o, 32'hFFFFFFFF);
        idle(1);
        chk("t1_ok_held", ok_o, 1);

        // Corrupted payload bit, immediate restart after done
        p[4] = p[4] ^ 8'h01;
        send_bits(p, 32'h765E7680, 0, -1, 1'b0);
        chk("t2_done", done_o, 1);
        chk("t2_ok", ok_o, 0);
        idle(1);

        // Empty payload, check field all ones
        send_bits(empty, 32'hFFFFFFFF, 0, -1, 1'b0);
        chk("t3_done", done_o, 1);
        chk("t3_ok", ok_o, 1);
        idle(1);

        // Timeout after 10 of 64 bits
        cyc(1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0, 1'b1, 1'($urandom), 1'b0);
        k = 41;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            if (done_o === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("t4_timeout_latency", 32'(k), 32'd16);
        chk("t4_timeout", timeout_o, 1);
        chk("t4_ok", ok_o, 0);
        idle(2);

        // Abort with a coincident bit mid-payload, start noise while busy
        p = digits();
        send_bits(p, cksum(p), 1, 7, 1'b1);
        chk("t5_abort_busy", busy_o, 0);
        chk("t5_abort_done", done_o, 0);
        idle(3);
        send_bits(p, cksum(p), 2, -1, 1'b1);
        chk("t5_fresh_ok", ok_o, 1);
        idle(1);

        // Asynchronous reset mid check field
        p = '{8'hA5, 8'h3C};
        send_bits(p, 32'h0, 0, -1, 1'b0);
        chk("t6_done_early", done_o, 1);
        idle(1);
        cyc(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) cyc(1'b0, 16'h0, 1'b1, 1'($urandom), 1'b0);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_done", done_o, 0);
        chk("t6_rst_ok", ok_o, 0);
        chk("t6_rst_timeout", timeout_o, 0);
        chk("t6_rst_residue", residue_o, 0);
        idle(2);
        reset_i = 1'b0;
        idle(1);
        send_bits(p, cksum(p), 1, -1, 1'b0);
        chk("t6_after_ok", ok_o, 1);
        idle(1);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            logic [31:0] cw;
            int          len, ab, total, n;
            p.delete();
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            cw = cksum(p);
            if ($urandom % 2 == 0) begin
                if (len > 0 && $urandom % 2 == 0)
                    p[$urandom_range(0, len - 1)] ^= 8'(1 << $urandom_range(0, 7));
                else
                    cw ^= 32'(1) << $urandom_range(0, 31);
            end
            total = len * 8 + 32;
            ab = ($urandom % 8 == 0) ? int'($urandom_range(0, total - 1)) : -1;
            send_bits(p, cw, 3, ab, 1'b1);
            idle(1);
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) cyc(1'b0, 16'h0, 1'($urandom), 1'($urandom), 1'b0);
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_frame_ctrl.md
# crc_frame_ctrl

Sequencer for a bit-serial CRC-32 engine (polynomial 0x04C11DB7, MSB-first, CRC-32/CKSUM parameters) checking SPI-received frames. Sits between the SPI bit deserializer and the frame consumer. It takes a start command with a payload length, gates the engine over payload bits and then the 32 check bits, and reports pass/fail. It also supports abort and an inactivity timeout.

## Interface
- LEN_W, 16, width of payload length in bytes
- TIMEOUT, 4096, clock cycles without an accepted bit before a frame is failed; 0 disables the timeout
- clk_i  in  1  system clock
- reset_i  in  1  reset; asynchronous, active-high
- start_i  in  1  begin a frame; accepted only in IDLE
- len_i  in  LEN_W  payload length in bytes; latched on accepted start; 0 is legal (check field only)
- bit_valid_i  in  1  bit strobe from the SPI deserializer, one cycle per bit
- bit_i  in  1  serial data bit, qualified by bit_valid_i
- abort_i  in  1  abandon the current frame
- busy_o  out  1  high in PAYLOAD and CHECK
- done_o  out  1  one-cycle completion pulse
- ok_o  out  1  frame passed; valid from done_o until the next accepted start
- timeout_o  out  1  frame failed by timeout; same validity as ok_o
- residue_o  out  32  live engine register, for debug

## Operation
- States: IDLE, PAYLOAD, CHECK, DONE.
- IDLE, start_i=1 on an edge:
  - Engine register cleared to 0; ok_o and timeout_o cleared.
  - Bit counter loaded with len_i*8 (width LEN_W+3).
  - Next state is PAYLOAD, or CHECK with counter=32 if len_i=0.
- PAYLOAD/CHECK, bit_valid_i=1 on an edge:
  - Engine shifts bit_i in that same edge: r <= {r[30:0],bit_i} ^ (r[31] ? 0x04C11DB7 : 0). There is no input register stage.
  - Counter decrements.
  - When the last payload bit is consumed, the next state is CHECK with counter=32.
  - When the 32nd check bit is consumed, the next state is DONE.
- DONE (exactly one cycle):
  - done_o=1.
  - ok_o <= (engine register == 0xFFFFFFFF), timeout_o=0.
  - Next state is IDLE.
- Pass rule: the check field equals the CRC-32/CKSUM of the payload (init 0, no reflection, xorout 0xFFFFFFFF), sent MSB first. That gives residue 0xFFFFFFFF.
- Timeout:
  - Cycle counter in PAYLOAD/CHECK; cleared on start and on every accepted bit.
  - When it reaches TIMEOUT, the next state is DONE with ok_o=0 and timeout_o=1.
- abort_i=1 in any non-IDLE state: next state is IDLE; no done_o; ok_o and timeout_o left at 0.
- Ignored inputs:
  - bit_valid_i in IDLE and DONE.
  - start_i outside IDLE.

## Timing
- Reset values: state IDLE, engine 0, counters 0, busy_o=0, done_o=0, ok_o=0, timeout_o=0, residue_o=0.
- Reset assertion forces these immediately, including mid-frame.
- Start latency: busy_o rises in the cycle after the accepted start edge. The first bit is accepted in that cycle.
- done_o is high in the cycle after the edge that consumed the final check bit, or after the edge where the timeout count hit TIMEOUT. busy_o is low in that cycle.
- Earliest restart: start_i is accepted in the cycle after done_o, which is back in IDLE.
- Simultaneous events, priority order:
  - abort_i over bit_valid_i and timeout.
  - bit_valid_i over timeout in the same cycle: the bit is accepted and the timeout counter clears.
- Back-to-back bit_valid_i on every cycle is supported.
- Counters never wrap: the bit counter stops at 0 on leaving CHECK, and the timeout counter saturates.

## Structure
- Package crc_frame_pkg:
  - State enum.
  - CRC_POLY=32'h04C11DB7, CRC_RESIDUE=32'hFFFFFFFF, CHECK_BITS=32.
- Sub-module crc32_lfsr:
  - Ports: clk_i, reset_i, clear_i, shift_i, bit_i, crc_o.
  - clear_i has priority over shift_i.
- The controller owns the FSM and counters and drives clear_i and shift_i.

## Test plan
- Payload "123456789" (len_i=9), then 0x765E7680 MSB first, one bit per cycle -> done_o 1 cycle after the 104th bit, ok_o=1, timeout_o=0, residue_o=0xFFFFFFFF.
- Same frame with bit 0 of payload byte 4 flipped -> done_o after 104 bits, ok_o=0.
- len_i=0, 32 ones -> done_o after 32 bits, ok_o=1.
- TIMEOUT=16, len_i=4, only 10 bits sent -> done_o 16 cycles after the 10th bit, ok_o=0, timeout_o=1.
- abort_i together with bit_valid_i mid-PAYLOAD -> IDLE next cycle, no done_o. start_i pulsed while busy is ignored. A fresh valid frame afterwards gives ok_o=1.
- reset_i asserted asynchronously mid-CHECK -> all outputs 0 immediately. After release, a valid frame passes.
